uart_rom_loader: RTL and testbench

- Synthesizable program loader that sits directly upstream of the SoC instruction ROM.
- Replaces the simulation-only ROM preload with a UART download path: it receives a framed binary image, assembles little-endian 32-bit words and drives the ROM write port.
- Holds the core in reset while a download is in progress and releases it only after a good checksum.
- Instantiated inside soc, between the board UART pin, the ROM write port and the core reset input.

---
 rtl/soc_defs.sv | 31 +++
 rtl/uart_rx.sv | 100 ++++++++++
 rtl/uart_rom_loader.sv | 161 ++++++++++++++++
 tb/tb_uart_rom_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_defs.sv
// Shared definitions for the SoC program-load path.
//   - ld_state_e : loader FSM states (IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR)
//   - rx_state_e : UART receiver bit-timing states
//   - SYNC_BYTE  : first byte of every download frame
//   - clks_per_bit() : clocks per UART bit (integer division)
package soc_defs;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN0,
    LD_LEN1,
    LD_DATA,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer plus 8N1 bit-timing FSM.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   rx_i          : asynchronous serial input, idle high
//   byte_o        : last received byte (stable while byte_valid_o is high)
//   byte_valid_o  : 1-cycle pulse, byte received with a good stop bit
//   frame_err_o   : 1-cycle pulse, stop bit sampled low (byte discarded)
// Handshake: byte_valid_o/frame_err_o are single-cycle strobes with no
// back-pressure; the consumer must accept the byte in the pulse cycle.
module uart_rx
  import soc_defs::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s1, rx_s2, rx_prev;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_d, ferr_d;

  assign byte_o = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_s1        <= rx_i;
      rx_s2        <= rx_s1;
      rx_prev      <= rx_s2;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_o <= valid_d;
      frame_err_o  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s2) state_d = RX_START;
      end
      RX_START: begin
        // Mid-bit re-check rejects glitches shorter than half a bit.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s2, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s2) valid_d = 1'b1;
          else       ferr_d  = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rom_loader.sv
// UART program loader in front of the instruction ROM.
// Receives frame: A5, LEN_L, LEN_H (N words), 4N data bytes (little-endian
// words), CSUM (mod-256 sum of data bytes). Writes each word to the ROM and
// holds the core in reset until a frame completes with a good checksum.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   uart_rx_i     : serial input, idle high
//   rom_we_o      : 1-cycle ROM write strobe per word
//   rom_waddr_o   : ROM word address (held between strobes)
//   rom_wdata_o   : ROM write data (held between strobes)
//   core_rst_n_o  : active-low core reset, high only in IDLE and DONE
//   load_busy_o   : frame in progress (LEN0..CSUM)
//   load_done_o   : last frame loaded with good checksum
//   load_err_o    : last frame failed
// All outputs are registered and derived from the next loader state.
module uart_rom_loader
  import soc_defs::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx_i,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_waddr_o,
  output logic [31:0]       rom_wdata_o,
  output logic              core_rst_n_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              load_err_o
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  // Word count is 16 bits; ADDR_W is assumed to be at most 16.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_ferr;

  ld_state_e   state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_idx_q;
  logic [7:0]  csum_q;
  logic [23:0] wbuf_q;       // lanes 0..2; lane 3 arrives with the write
  logic [TMR_W-1:0] tmr_q;

  logic        busy_now, timeout, last_word;
  logic [16:0] len_next;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (uart_rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_ferr)
  );

  assign busy_now  = state_q inside {LD_LEN0, LD_LEN1, LD_DATA, LD_CSUM};
  assign timeout   = busy_now && (tmr_q == TMR_LAST);
  assign last_word = (word_idx_q == len_q - 16'd1);
  assign len_next  = {1'b0, rx_byte, len_q[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (rx_valid && rx_byte == SYNC_BYTE) state_d = LD_LEN0;
      end
      LD_LEN0: if (rx_valid) state_d = LD_LEN1;
      LD_LEN1: begin
        if (rx_valid) begin
          if (len_next == 17'd0)         state_d = LD_CSUM;
          else if (len_next > CAPACITY)  state_d = LD_ERR;
          else                           state_d = LD_DATA;
        end
      end
      LD_DATA: begin
        if (rx_valid && byte_idx_q == 2'd3 && last_word) state_d = LD_CSUM;
      end
      LD_CSUM: begin
        if (rx_valid) state_d = (rx_byte == csum_q) ? LD_DONE : LD_ERR;
      end
      default: state_d = LD_IDLE;
    endcase
    // A received byte takes priority over a same-cycle timeout.
    if (busy_now && !rx_valid && (rx_ferr || timeout)) state_d = LD_ERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      csum_q       <= '0;
      wbuf_q       <= '0;
      tmr_q        <= '0;
      rom_we_o     <= 1'b0;
      rom_waddr_o  <= '0;
      rom_wdata_o  <= '0;
      core_rst_n_o <= 1'b0;
      load_busy_o  <= 1'b0;
      load_done_o  <= 1'b0;
      load_err_o   <= 1'b0;
    end else begin
      rom_we_o <= 1'b0;

      if (!busy_now || rx_valid) tmr_q <= '0;
      else                       tmr_q <= tmr_q + 1'b1;

      if (rx_valid) begin
        case (state_q)
          LD_IDLE, LD_DONE, LD_ERR: begin
            if (rx_byte == SYNC_BYTE) begin
              word_idx_q <= '0;
              byte_idx_q <= '0;
              csum_q     <= '0;
            end
          end
          LD_LEN0: len_q[7:0]  <= rx_byte;
          LD_LEN1: len_q[15:8] <= rx_byte;
          LD_DATA: begin
            csum_q     <= csum_q + rx_byte;
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: wbuf_q[7:0]   <= rx_byte;
              2'd1: wbuf_q[15:8]  <= rx_byte;
              2'd2: wbuf_q[23:16] <= rx_byte;
              default: begin
                rom_we_o    <= 1'b1;
                rom_waddr_o <= word_idx_q[ADDR_W-1:0];
                rom_wdata_o <= {rx_byte, wbuf_q};
                word_idx_q  <= word_idx_q + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end

      core_rst_n_o <= state_d inside {LD_IDLE, LD_DONE};
      load_busy_o  <= state_d inside {LD_LEN0, LD_LEN1, LD_DATA, LD_CSUM};
      load_done_o  <= (state_d == LD_DONE);
      load_err_o   <= (state_d == LD_ERR);
    end
  end

endmodule

// File: tb/tb_uart_rom_loader.sv
`timescale 1ns/1ps
module tb_uart_rom_loader;

  localparam int CLK_FREQ    = 1000000;
  localparam int BAUD        = 100000;
  localparam int ADDR_W      = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int BIT_CLKS    = CLK_FREQ / BAUD;
  localparam int CAP         = 1 << ADDR_W;
  localparam logic [7:0] SYNC = 8'hA5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx_i = 1'b1;
  always #5 clk = ~clk;

  logic              rom_we_o;
  logic [ADDR_W-1:0] rom_waddr_o;
  logic [31:0]       rom_wdata_o;
  logic              core_rst_n_o, load_busy_o, load_done_o, load_err_o;

  uart_rom_loader #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx_i   (uart_rx_i),
    .rom_we_o    (rom_we_o),
    .rom_waddr_o (rom_waddr_o),
    .rom_wdata_o (rom_wdata_o),
    .core_rst_n_o(core_rst_n_o),
    .load_busy_o (load_busy_o),
    .load_done_o (load_done_o),
    .load_err_o  (load_err_o)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0] rom_model [CAP];
  logic [31:0] frame_words [CAP];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ROM write must match the oldest expected write.
  always @(negedge clk) begin
    if (rom_we_o) begin
      rom_model[rom_waddr_o] = rom_wdata_o;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %08h expected no write",
                 rom_waddr_o, rom_wdata_o);
      end else begin
        check("rom_write", 64'({rom_waddr_o, rom_wdata_o}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx_i = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      idle(BIT_CLKS);
    end
    uart_rx_i = stop_bit;
    idle(BIT_CLKS);
    uart_rx_i = 1'b1;
    idle($urandom_range(1, 4));
  endtask

  task automatic check_status(input string tag, input logic busy, input logic done,
                              input logic err, input logic core);
    check({tag, "_busy"}, 64'(load_busy_o), 64'(busy));
    check({tag, "_done"}, 64'(load_done_o), 64'(done));
    check({tag, "_err"},  64'(load_err_o),  64'(err));
    check({tag, "_core_rst_n"}, 64'(core_rst_n_o), 64'(core));
  endtask

  // Reference model: word i lands at address i; the frame is good when the
  // transmitted checksum equals the mod-256 sum of the data bytes.
  task automatic send_frame(input int n, input logic [15:0] len_field, input bit corrupt);
    logic [7:0] sum;
    logic [7:0] b;
    sum = 8'h00;
    send_byte(SYNC, 1'b1);
    check_status("after_sync", 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(len_field[7:0], 1'b1);
    send_byte(len_field[15:8], 1'b1);
    if (int'(len_field) > CAP) begin
      idle(3);
      check_status("oversize", 1'b0, 1'b0, 1'b1, 1'b0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({ADDR_W'(i), frame_words[i]});
      for (int j = 0; j < 4; j++) begin
        b = frame_words[i][8*j +: 8];
        sum = sum + b;
        send_byte(b, 1'b1);
      end
    end
    send_byte(corrupt ? sum + 8'd1 : sum, 1'b1);
    idle(3);
    check_status(corrupt ? "bad_frame" : "good_frame", 1'b0, !corrupt, corrupt, !corrupt);
    check("pending_writes", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic load_two_words();
    frame_words[0] = 32'h0000_0013;
    frame_words[1] = 32'h0010_00B3;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w0;
    int n;

    // Reset release
    rst_n = 1'b0;
    idle(3);
    check("rst_rom_we", 64'(rom_we_o), 64'(0));
    check("rst_waddr", 64'(rom_waddr_o), 64'(0));
    check("rst_wdata", 64'(rom_wdata_o), 64'(0));
    check_status("in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(1);
    check_status("after_release", 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Good 2-word load (checksum D6)
    load_two_words();
    send_frame(2, 16'd2, 1'b0);

    // Bad checksum (D7), then the good frame again
    send_frame(2, 16'd2, 1'b1);
    send_frame(2, 16'd2, 1'b0);

    // Glitch shorter than half a bit in DONE: nothing decoded
    @(negedge clk);
    uart_rx_i = 1'b0;
    idle(3);
    uart_rx_i = 1'b1;
    idle(40);
    check_status("after_glitch", 1'b0, 1'b1, 1'b0, 1'b1);

    // Garbage byte before sync is ignored
    send_byte(8'h5A, 1'b1);
    idle(3);
    check_status("after_garbage", 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(2, 16'd2, 1'b0);

    // Stop bit 0 inside DATA -> ERR (word 0 already written)
    send_byte(SYNC, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    exp_q.push_back({ADDR_W'(0), 32'hDEAD_BEEF});
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(3);
    check_status("framing_err", 1'b0, 1'b0, 1'b1, 1'b0);
    check("framing_pending", 64'(exp_q.size()), 64'(0));

    // Oversize length 0x0011 -> ERR after LEN_H, no write
    send_frame(0, 16'h0011, 1'b0);

    // Exactly full capacity
    for (int i = 0; i < CAP; i++) frame_words[i] = $urandom;
    send_frame(CAP, 16'(CAP), 1'b0);

    // Zero-length frame: checksum 00
    send_frame(0, 16'd0, 1'b0);

    // Timeout: stop after 2 data bytes
    send_byte(SYNC, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(290);
    check_status("before_timeout", 1'b1, 1'b0, 1'b0, 1'b0);
    idle(15);
    check_status("after_timeout", 1'b0, 1'b0, 1'b1, 1'b0);

    // Random frames
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) frame_words[i] = $urandom;
      send_frame(n, 16'(n), ($urandom_range(0, 3) == 0));
    end

    // Reset during DATA word 1
    w0 = $urandom;
    send_byte(SYNC, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    exp_q.push_back({ADDR_W'(0), w0});
    for (int j = 0; j < 4; j++) send_byte(w0[8*j +: 8], 1'b1);
    send_byte(8'h77, 1'b1);
    idle(20);
    check("midload_busy", 64'(load_busy_o), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_rom_we", 64'(rom_we_o), 64'(0));
    check("midrst_waddr", 64'(rom_waddr_o), 64'(0));
    check("midrst_wdata", 64'(rom_wdata_o), 64'(0));
    check_status("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rom_word0_retained", 64'(rom_model[0]), 64'(w0));
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check_status("mid_release", 1'b0, 1'b0, 1'b0, 1'b1);

    // Recovery with a fresh good frame
    load_two_words();
    send_frame(2, 16'd2, 1'b0);
    check("final_pending", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
